// File: rtl/div_defs_pkg.sv
// Shared definitions for the iterative divider: widths, iteration count, state
// encodings, result payload and a conditional-negate helper.
package div_defs_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned DIV_CYCLES = 32;
  localparam int unsigned CNT_W      = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] hi;  // remainder
    logic [DATA_W-1:0] lo;  // quotient
  } div_result_t;

  // Two's-complement negate when neg is set.
  function automatic logic [DATA_W-1:0] neg_if(input logic neg, input logic [DATA_W-1:0] v);
    return neg ? DATA_W'(-v) : v;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Restoring radix-2 DIV/DIVU unit for the execute stage, one quotient bit per cycle.
// Define DIV_ZERO_FAST_EN to short-circuit a zero divisor straight to the result.
module div_unit
  import div_defs_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                startE,
  input  logic                signedE,
  input  logic [DATA_W-1:0]   srcAE,
  input  logic [DATA_W-1:0]   srcBE,
  input  logic                cancelE,
  output logic                stall_divE,
  output logic [2*DATA_W-1:0] div_resultE,
  output logic                div_readyE
);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   divisor;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;
  logic                sign_a;
  logic                sign_b;
  logic                is_signed;
  div_result_t         result_q;
  logic                ready_q;

  logic [DATA_W:0]     shifted;
  logic [DATA_W:0]     diff;
  logic                step_ok;
  logic [DATA_W-1:0]   rem_nxt;
  logic [DATA_W-1:0]   quo_nxt;
  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  div_result_t         final_res;

  // One restoring step plus operand magnitudes and the sign-corrected final result.
  always_comb begin
    shifted   = {rem, quo[DATA_W-1]};
    diff      = shifted - {1'b0, divisor};
    step_ok   = ~diff[DATA_W];
    rem_nxt   = step_ok ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    quo_nxt   = {quo[DATA_W-2:0], step_ok};
    mag_a     = neg_if(signedE & srcAE[DATA_W-1], srcAE);
    mag_b     = neg_if(signedE & srcBE[DATA_W-1], srcBE);
    final_res = '0;
    final_res.hi = neg_if(is_signed & sign_a, rem_nxt);
    final_res.lo = neg_if(is_signed & (sign_a ^ sign_b), quo_nxt);
  end

  assign stall_divE  = ~rst & ~cancelE &
                       (((state == IDLE) & startE) | (state == BUSY));
  assign div_resultE = result_q;
  assign div_readyE  = ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      divisor   <= '0;
      quo       <= '0;
      rem       <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      is_signed <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else if (cancelE) begin
      state   <= IDLE;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (startE) begin
            divisor   <= mag_b;
            quo       <= mag_a;
            rem       <= '0;
            sign_a    <= signedE & srcAE[DATA_W-1];
            sign_b    <= signedE & srcBE[DATA_W-1];
            is_signed <= signedE;
            cnt       <= '0;
`ifdef DIV_ZERO_FAST_EN
            if (srcBE == '0) begin
              // Zero divisor has a fixed answer; skip the iterations.
              result_q.hi <= neg_if(signedE & srcAE[DATA_W-1], mag_a);
              result_q.lo <= neg_if(signedE & srcAE[DATA_W-1], '1);
              ready_q     <= 1'b1;
              state       <= DONE;
            end else begin
              state <= BUSY;
            end
`else
            state <= BUSY;
`endif
          end
        end
        BUSY: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DIV_CYCLES - 1)) begin
            result_q <= final_res;
            ready_q  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results,
// zero divisor, cancel and reset behaviour.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        startE;
  logic        signedE;
  logic [31:0] srcAE;
  logic [31:0] srcBE;
  logic        cancelE;
  logic        stall_divE;
  logic [63:0] div_resultE;
  logic        div_readyE;

  int tests = 0;
  int fails = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT   = 1;
  localparam int ZERO_STALL = 1;
`else
  localparam int ZERO_LAT   = 33;
  localparam int ZERO_STALL = 33;
`endif

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .startE     (startE),
    .signedE    (signedE),
    .srcAE      (srcAE),
    .srcBE      (srcBE),
    .cancelE    (cancelE),
    .stall_divE (stall_divE),
    .div_resultE(div_resultE),
    .div_readyE (div_readyE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count ready pulses over a fixed window with no new request.
  task automatic count_ready(output int pulses);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (div_readyE) pulses++;
      step();
    end
  endtask

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int exp_lat, input int exp_stall,
                         input logic hold, input string tag);
    int stalls;
    int lat;
    int pulses;
    logic [63:0] res;
    startE  = 1'b1;
    signedE = sgn;
    srcAE   = a;
    srcBE   = b;
    #1;
    stalls = 0;
    lat    = -1;
    pulses = 0;
    res    = '0;
    for (int i = 0; i < 40; i++) begin
      if (stall_divE) stalls++;
      if (div_readyE) begin
        pulses++;
        if (lat < 0) begin
          lat = i;
          res = div_resultE;
        end
      end
      @(posedge clk);
      #1;
      if (!hold || lat >= 0) startE = 1'b0;
      #1;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_stall"}, 64'(stalls), 64'(exp_stall));
    chk({tag, "_pulses"}, 64'(pulses), 64'd1);
    chk({tag, "_result"}, res, exp);
  endtask

  initial begin
    int pulses;
    rst     = 1'b1;
    startE  = 1'b0;
    signedE = 1'b0;
    srcAE   = '0;
    srcBE   = '0;
    cancelE = 1'b0;
    step();
    step();
    chk("reset_stall", 64'(stall_divE), 64'd0);
    chk("reset_ready", 64'(div_readyE), 64'd0);
    chk("reset_result", div_resultE, 64'd0);
    rst = 1'b0;
    step();

    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 33, 1'b0, "divu_100_7");
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 33, 1'b0, "div_m7_2");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33, 33, 1'b0, "div_7_m2");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, 33, 1'b0, "div_ovf");
    run_div(1'b1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'd1}, ZERO_LAT, ZERO_STALL, 1'b0, "div_m5_0");
    run_div(1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, ZERO_LAT, ZERO_STALL, 1'b0, "divu_5_0");

    // Cancel while the counter reads 10.
    startE  = 1'b1;
    signedE = 1'b0;
    srcAE   = 32'd100;
    srcBE   = 32'd7;
    step();
    startE  = 1'b0;
    repeat (10) step();
    cancelE = 1'b1;
    step();
    cancelE = 1'b0;
    #1;
    chk("cancel_stall_next", 64'(stall_divE), 64'd0);
    count_ready(pulses);
    chk("cancel_no_ready", 64'(pulses), 64'd0);
    chk("cancel_result_held", div_resultE, {32'd5, 32'hFFFF_FFFF});
    run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 33, 1'b0, "divu_9_3");

    // Start and cancel in the same idle cycle.
    startE  = 1'b1;
    cancelE = 1'b1;
    srcAE   = 32'd50;
    srcBE   = 32'd5;
    #1;
    chk("startcancel_stall", 64'(stall_divE), 64'd0);
    step();
    startE  = 1'b0;
    cancelE = 1'b0;
    #1;
    chk("startcancel_stall_next", 64'(stall_divE), 64'd0);
    count_ready(pulses);
    chk("startcancel_no_ready", 64'(pulses), 64'd0);

    // Reset while the counter reads 20.
    startE = 1'b1;
    srcAE  = 32'd100;
    srcBE  = 32'd7;
    step();
    startE = 1'b0;
    repeat (20) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midreset_stall", 64'(stall_divE), 64'd0);
    chk("midreset_ready", 64'(div_readyE), 64'd0);
    chk("midreset_result", div_resultE, 64'd0);
    count_ready(pulses);
    chk("midreset_no_ready", 64'(pulses), 64'd0);

    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 33, 1'b1, "hold_start");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: startE  in  1  DIV/DIVU instruction present in execute stage.
REQ-004 SHALL have: signedE  in  1  1 = DIV (signed), 0 = DIVU.
REQ-005 SHALL have: srcAE, srcBE  in  32 each  dividend and divisor.
REQ-006 SHALL have: cancelE  in  1  abandon the current operation (exception/flush).
REQ-007 SHALL have: stall_divE  out  1  holds F/D/E while the divide is in progress.
REQ-008 SHALL have: div_resultE  out  64  {hi = remainder, lo = quotient}.
REQ-009 SHALL have: div_readyE  out  1  div_resultE valid this cycle; hilo write enable.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-011 IDLE with startE=1 and cancelE=0: SHALL latch |srcAE|, |srcBE| (magnitudes when signedE=1), both operand signs and signedE, clear the 5-bit counter and go to BUSY.
REQ-012 stall_divE SHALL be combinational: (IDLE & startE & !cancelE) | BUSY; it SHALL be 0 in DONE.
REQ-013 BUSY SHALL perform one restoring radix-2 step per cycle (shift remainder, trial-subtract divisor, set quotient bit) for exactly 32 cycles (counter 0..31).
REQ-014 On the counter=31 cycle SHALL apply sign correction and register the result: quotient negated if operand signs differ; remainder takes the dividend's sign; then go to DONE.
REQ-015 DONE SHALL assert div_readyE=1 for exactly one cycle, drive div_resultE, ignore startE and return to IDLE.
REQ-016 Latency: start seen in cycle N; stall_divE=1 in cycles N..N+32; div_readyE=1 in cycle N+33.
REQ-017 div_resultE SHALL hold its last value outside DONE; div_readyE SHALL be 0 outside DONE.
REQ-018 Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0, with no trap.
REQ-019 Divisor 0 SHALL yield magnitudes quotient=0xFFFFFFFF and remainder=|dividend|, sign-corrected per REQ-014.
REQ-020 cancelE=1 in any state SHALL force IDLE on the next edge with stall_divE=0 that cycle and no div_readyE.
REQ-021 cancelE and startE in the same IDLE cycle SHALL leave the block in IDLE.

Reset
REQ-022 rst=1 SHALL set state=IDLE, counter=0, div_resultE=0, div_readyE=0 and stall_divE=0, overriding any operation in progress.

Configuration
REQ-023 Macro DIV_ZERO_FAST_EN SHALL select divide-by-zero handling.
- Defined: divisor 0 in IDLE goes directly to DONE with the REQ-019 result; stall_divE is high for 1 cycle and div_readyE rises at N+1.
- Undefined: divisor 0 runs the full 32 iterations with the identical result at N+33.

Structure
REQ-024 Shared header div_defs SHALL hold the state encodings, DIV_CYCLES=32 and the operand width 32.
REQ-025 No sub-module; the iteration step and the sign handling SHALL stay inline in div_unit.

Verification
REQ-026 DIVU 100/7 -> stall high 33 cycles; div_readyE at N+33; lo=14, hi=2.
REQ-027 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
REQ-028 DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-029 DIVU 5/0 -> lo=0xFFFFFFFF, hi=5; ready at N+1 with DIV_ZERO_FAST_EN, N+33 without.
REQ-030 cancelE at BUSY cycle 10 -> stall_divE 0 next cycle, no div_readyE; a new DIVU 9/3 then gives lo=3, hi=0.
REQ-031 rst at BUSY cycle 20 -> next cycle IDLE, outputs 0; startE held high through DONE -> exactly one div_readyE pulse.
